// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first,
// with a single borrow flop and a start/done handshake.
module serial_subtractor #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = (Width > 2) ? $clog2(Width) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  if (Width < 2 || Width > 64) begin : gen_width_check
    $error("serial_subtractor: Width must be in 2..64");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;
  logic [Width-1:0] res_q, res_d;
  logic [Width-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic ai, bi, d_bit, bw_next, last_bit;

  assign ai       = a_q[0];
  assign bi       = b_q[0];
  assign d_bit    = ai ^ bi ^ bw_q;
  assign bw_next  = (~ai & bi) | (~(ai ^ bi) & bw_q);
  assign last_bit = (cnt_q == CntLast);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          res_d   = '0;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        res_d = {d_bit, res_q[Width-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bw_d  = bw_next;
        if (last_bit) begin
          // On the last bit ai/bi are the original operand MSBs and d_bit is the result MSB.
          diff_d   = {d_bit, res_q[Width-1:1]};
          borrow_d = bw_next;
          ovf_d    = (ai ^ bi) & (d_bit ^ ai);
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff_o     = diff_q;
  assign borrow_o   = borrow_q;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q == StRun);
  assign done_o     = (state_q == StDone);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit and a 32-bit instance, expected results
// queued at issue time and checked by per-instance monitors on each done pulse.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, diff8;
  logic        borrow8, ovf8, busy8, done8;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, diff32;
  logic        borrow32, ovf32, busy32, done32;

  serial_subtractor #(.Width(8)) dut8 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start8),
    .a_i       (a8),
    .b_i       (b8),
    .diff_o    (diff8),
    .borrow_o  (borrow8),
    .overflow_o(ovf8),
    .busy_o    (busy8),
    .done_o    (done8)
  );

  serial_subtractor #(.Width(32)) dut32 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start32),
    .a_i       (a32),
    .b_i       (b32),
    .diff_o    (diff32),
    .borrow_o  (borrow32),
    .overflow_o(ovf32),
    .busy_o    (busy32),
    .done_o    (done32)
  );

  typedef struct packed {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done8) begin
      exp_t e;
      n_vec++;
      if (q8.size() == 0) begin
        n_err++;
        $display("FAIL dut8_unexpected_done: got diff=%h with no pending request", diff8);
      end else begin
        e = q8.pop_front();
        if ({diff8, borrow8, ovf8, busy8} !== {e.diff[7:0], e.borrow, e.ovf, 1'b0}) begin
          n_err++;
          $display("FAIL dut8_result: got diff=%h bw=%b ov=%b busy=%b, want diff=%h bw=%b ov=%b busy=0",
                   diff8, borrow8, ovf8, busy8, e.diff[7:0], e.borrow, e.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done32) begin
      exp_t e;
      n_vec++;
      if (q32.size() == 0) begin
        n_err++;
        $display("FAIL dut32_unexpected_done: got diff=%h with no pending request", diff32);
      end else begin
        e = q32.pop_front();
        if ({diff32, borrow32, ovf32, busy32} !== {e.diff, e.borrow, e.ovf, 1'b0}) begin
          n_err++;
          $display("FAIL dut32_result: got diff=%h bw=%b ov=%b busy=%b, want diff=%h bw=%b ov=%b busy=0",
                   diff32, borrow32, ovf32, busy32, e.diff, e.borrow, e.ovf);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                      input logic eb, input logic eo, input bit chk_lat);
    int k;
    bit seen;
    a8 = a; b8 = b; start8 = 1'b1;
    q8.push_back('{diff: {24'h0, ed}, borrow: eb, ovf: eo});
    @(posedge clk);
    #1 start8 = 1'b0;
    if (chk_lat) check("busy8_after_start", {63'h0, busy8}, 64'h1);
    seen = 0;
    for (k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin seen = 1; break; end
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL dut8_timeout: got no done in 12 cycles, want done");
    end else if (chk_lat) begin
      check("dut8_latency", 64'(k), 64'd8);
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                       input logic eb, input logic eo);
    bit seen;
    a32 = a; b32 = b; start32 = 1'b1;
    q32.push_back('{diff: ed, borrow: eb, ovf: eo});
    @(posedge clk);
    #1 start32 = 1'b0;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done32) begin seen = 1; break; end
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL dut32_timeout: got no done in 40 cycles, want done");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb, rd;
    int          t_done[3];
    int          pulses;
    int          n;

    repeat (2) @(negedge clk);
    check("reset8_outputs", {44'h0, diff8, borrow8, ovf8, busy8, done8}, 64'h0);
    check("reset32_outputs", {28'h0, diff32, borrow32, ovf32, busy32, done32}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    run8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    run8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    @(negedge clk);

    // Reset mid-operation: 0x40-0x01 is discarded, no expectation is queued for it.
    a8 = 8'h40; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_op", {54'h0, diff8, busy8, done8}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    run32(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0);
    run32(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run32(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);

    // start and operand changes during RUN must be ignored.
    a32 = 32'h0; b32 = 32'h0; start32 = 1'b1;
    q32.push_back('{diff: 32'h0, borrow: 1'b0, ovf: 1'b0});
    @(posedge clk);
    #1 start32 = 1'b0;
    @(negedge clk);
    a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    a32 = 32'hDEAD_BEEF; b32 = 32'hFFFF_0001;
    repeat (80) @(negedge clk);
    check("ignore_start_queue", 64'(q32.size()), 64'd0);

    // Held start: three back-to-back operations, done every 33 cycles.
    a32 = 32'h0000_0010; b32 = 32'h0000_0020; start32 = 1'b1;
    repeat (3) q32.push_back('{diff: 32'hFFFF_FFF0, borrow: 1'b1, ovf: 1'b0});
    pulses = 0;
    for (n = 1; n <= 150; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done32) begin
        t_done[pulses] = n;
        pulses++;
        if (pulses == 3) begin start32 = 1'b0; break; end
      end
    end
    start32 = 1'b0;
    check("held_pulse_count", 64'(pulses), 64'd3);
    if (pulses == 3) begin
      check("held_first_done", 64'(t_done[0]), 64'd33);
      check("held_spacing_1", 64'(t_done[1] - t_done[0]), 64'd33);
      check("held_spacing_2", 64'(t_done[2] - t_done[1]), 64'd33);
    end
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i % 4 == 0) rb = ra ^ (32'h1 << (i % 32));
      rd = ra - rb;
      run32(ra, rb, rd, ra < rb, (ra[31] != rb[31]) && (rd[31] != ra[31]));
    end

    repeat (45) @(negedge clk);
    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q32_drained", 64'(q32.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
